button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//  Consumer end of the debounced-button interface: takes one clean level from a debouncer and converts it to discrete events.
//  Events: PRESS, RELEASE, LONG (held past threshold), REPEAT (auto-repeat while held).
//  Presents one event at a time to control logic (SEC-DED demo UI) over a valid/ack handshake.
//  Sits between the board-button debouncer and the menu/control FSM; all logic on clk_50M.
// PARAMETERS
//  TICK_COUNT    50_000  clk_50M cycles per timing tick (1 ms at 50 MHz); >= 2
//  LONG_TICKS    1000    ticks held after PRESS before the LONG event; >= 1
//  REPEAT_TICKS  200     ticks between successive REPEAT events after LONG; >= 1
// PORTS
//  clk_50M   in   1  system clock, 50 MHz
//  rst       in   1  asynchronous, active-high reset
//  D_deb     in   1  debounced button level, 1 = pressed; asynchronous to clk_50M
//  ev_ack    in   1  consumer accepts current event when sampled high with ev_valid
//  ovf_clr   in   1  clears ev_ovf
//  ev_valid  out  1  event pending
//  ev_code   out  2  0=PRESS 1=RELEASE 2=LONG 3=REPEAT; stable while ev_valid
//  ev_ovf    out  1  sticky: an event was dropped
//  btn_held  out  1  high whenever FSM is not IDLE
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; sync flops, d_prev, tick and hold counters = 0; ev_valid=0, ev_code=0, ev_ovf=0, btn_held=0.
//  Input path: 2-flop synchronizer d_s1->d_s2; d_prev <= d_s2; rise = d_s2&~d_prev, fall = ~d_s2&d_prev.
//  Latency: a D_deb change is reflected on ev_valid at the 3rd rising clk_50M edge after it.
//  Button held through reset release: produces one PRESS (sync/d_prev reset to 0). This is required.
//  Tick gen: counter 0..TICK_COUNT-1, tick = 1 for one cycle at TICK_COUNT-1; cleared to 0 on rise.
//    First tick therefore comes TICK_COUNT cycles after the rise cycle.
//  FSM:
//    IDLE: on rise -> emit PRESS, hold_cnt=0, go PRESSED.
//    PRESSED: on fall -> emit RELEASE, go IDLE.
//      On tick: hold_cnt++; when it reaches LONG_TICKS -> emit LONG, hold_cnt=0, go REPEAT.
//    REPEAT: on fall -> emit RELEASE, go IDLE.
//      On tick: hold_cnt++; when it reaches REPEAT_TICKS -> emit REPEAT, hold_cnt=0.
//  Same-cycle fall and tick threshold: fall wins, only RELEASE is emitted.
//  Counters: hold_cnt width $clog2(max(LONG_TICKS,REPEAT_TICKS)+1); tick width $clog2(TICK_COUNT).
//    Both never exceed their threshold, so no wrap.
//  Handshake:
//    ev_valid rises with ev_code loaded; it holds until a cycle with ev_valid&ev_ack.
//    That cycle with no new event: ev_valid drops next edge.
//    Ack and new event in the same cycle: new code loads, ev_valid stays 1 (no bubble).
//    New event while ev_valid=1 and ev_ack=0: event dropped, ev_code unchanged, ev_ovf <= 1.
//    FSM still advances on a dropped event.
//  ev_ovf: cleared by ovf_clr; if ovf_clr and a drop happen in the same cycle, set wins.
//  ev_ack with ev_valid=0 is ignored.
//  Assertions: ev_code stable while ev_valid&~ev_ack; never LONG/REPEAT when btn_held was 0 the prior cycle.
// STRUCTURE
//  Package btn_evt_pkg:
//    typedef enum logic[1:0] {IDLE, PRESSED, REPEAT} btn_state_t
//    typedef enum logic[1:0] {EV_PRESS=0, EV_RELEASE=1, EV_LONG=2, EV_REPEAT=3} btn_ev_t
//  Sub-module tick_gen (params TICK_COUNT; ports clk_50M, rst, clr, tick).
//  Top holds the synchronizer, FSM, hold counter and event register.
// TESTING (bench params TICK_COUNT=4, LONG_TICKS=3, REPEAT_TICKS=2)
//  1. Press, hold 8 cycles, release, ev_ack tied 1.
//     -> PRESS at edge 3 after rise; RELEASE at edge 3 after fall; no LONG; btn_held 1 in between.
//  2. Press, hold 40 cycles, ack tied 1.
//     -> PRESS; LONG 12 cycles after rise cycle; REPEAT every 8 cycles thereafter; RELEASE after fall.
//  3. Press, ev_ack=0 for 20 cycles, then release.
//     -> ev_code stays 0 (PRESS), ev_ovf=1 after the drop.
//     -> ack, then one ovf_clr pulse -> ev_valid=0, ev_ovf=0.
//  4. Time fall to coincide with the LONG threshold tick -> only RELEASE (code 1) emitted, state IDLE.
//  5. Assert rst mid-REPEAT with ev_valid=1 -> all outputs 0 immediately (before next clock edge).
//     -> With D_deb still 1 after rst release: one PRESS 3 edges later.
//  6. Ack pulsed on the same cycle a REPEAT is produced -> ev_valid stays 1 continuously, ev_code=3, ev_ovf=0.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared types and helpers for the button event decoder
package btn_evt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_t;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_RELEASE = 2'd1,
        EV_LONG    = 2'd2,
        EV_REPEAT  = 2'd3
    } btn_ev_t;

    // Larger of two thresholds; sizes the shared hold counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// rtl/button_event_decoder_if.sv - button level in, event handshake out
interface button_event_decoder_if;

    logic       D_deb;
    logic       ev_ack;
    logic       ovf_clr;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_ovf;
    logic       btn_held;

    // Control logic side: drives the level and ack, consumes events.
    modport master (
        output D_deb, ev_ack, ovf_clr,
        input  ev_valid, ev_code, ev_ovf, btn_held
    );

    // Decoder side.
    modport slave (
        input  D_deb, ev_ack, ovf_clr,
        output ev_valid, ev_code, ev_ovf, btn_held
    );

endinterface

// File: rtl/button_event_decoder_tick_gen.sv
// rtl/button_event_decoder_tick_gen.sv - free-running timing tick, restartable on press
module tick_gen #(
    parameter int TICK_COUNT = 50_000
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            TW   = $clog2(TICK_COUNT);
    localparam logic [TW-1:0] LAST = TW'(TICK_COUNT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Count 0..TICK_COUNT-1; clearing aligns the first tick to the press.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced button level to PRESS/RELEASE/LONG/REPEAT events
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int TICK_COUNT   = 50_000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    button_event_decoder_if.slave bus
);

    localparam int            HW          = $clog2(max_int(LONG_TICKS, REPEAT_TICKS) + 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

    logic       d_s1_q, d_s2_q, d_prev_q;
    logic       rise, fall, tick;
    btn_state_t state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic       fire;
    btn_ev_t    fire_code;
    logic       ev_valid_q, ev_valid_d;
    btn_ev_t    ev_code_q, ev_code_d;
    logic       ev_ovf_q, ev_ovf_d;
    logic       drop;

    // Synchronize the asynchronous level and keep one cycle of history for edges.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            d_s1_q   <= 1'b0;
            d_s2_q   <= 1'b0;
            d_prev_q <= 1'b0;
        end else begin
            d_s1_q   <= bus.D_deb;
            d_s2_q   <= d_s1_q;
            d_prev_q <= d_s2_q;
        end
    end

    assign rise = d_s2_q & ~d_prev_q;
    assign fall = ~d_s2_q & d_prev_q;

    tick_gen #(
        .TICK_COUNT (TICK_COUNT)
    ) u_tick_gen (
        .clk_50M (clk_50M),
        .rst     (rst),
        .clr     (rise),
        .tick    (tick)
    );

    // Button FSM: decides which event fires this cycle; a fall beats a threshold tick.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        fire      = 1'b0;
        fire_code = EV_PRESS;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    fire      = 1'b1;
                    fire_code = EV_PRESS;
                    hold_d    = '0;
                    state_d   = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    fire      = 1'b1;
                    fire_code = EV_RELEASE;
                    state_d   = IDLE;
                end else if (tick) begin
                    if (hold_q == LONG_LAST) begin
                        fire      = 1'b1;
                        fire_code = EV_LONG;
                        hold_d    = '0;
                        state_d   = REPEAT;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    fire      = 1'b1;
                    fire_code = EV_RELEASE;
                    state_d   = IDLE;
                end else if (tick) begin
                    if (hold_q == REPEAT_LAST) begin
                        fire      = 1'b1;
                        fire_code = EV_REPEAT;
                        hold_d    = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // FSM state and hold counter registers.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Event slot: load when free or being acked, otherwise drop and flag overflow.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        drop       = fire & ev_valid_q & ~bus.ev_ack;
        if (fire) begin
            if (!drop) begin
                ev_valid_d = 1'b1;
                ev_code_d  = fire_code;
            end
        end else if (ev_valid_q && bus.ev_ack) begin
            ev_valid_d = 1'b0;
        end
        if (drop) begin
            ev_ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ev_ovf_d = 1'b0;
        end else begin
            ev_ovf_d = ev_ovf_q;
        end
    end

    // Event slot registers.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_PRESS;
            ev_ovf_q   <= 1'b0;
        end else begin
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_ovf_q   <= ev_ovf_d;
        end
    end

    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_code  = ev_code_q;
    assign bus.ev_ovf   = ev_ovf_q;
    assign bus.btn_held = (state_q != IDLE);

    // A pending, unacknowledged event must not change under the consumer.
    a_code_stable: assert property (@(posedge clk_50M) disable iff (rst)
        (ev_valid_q && !bus.ev_ack) |=> $stable(ev_code_q));

    // LONG/REPEAT only ever originate from a held button.
    a_hold_events: assert property (@(posedge clk_50M) disable iff (rst)
        (fire && (fire_code == EV_LONG || fire_code == EV_REPEAT)) |-> (state_q != IDLE));

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed checks of the button event decoder
module tb_button_event_decoder;

    typedef struct {
        logic       d;
        logic       ack;
        logic       clr;
        logic       v;
        logic [1:0] c;
        logic       o;
        logic       h;
    } vec_t;

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    vec_t tbl [13];

    button_event_decoder_if bif ();

    button_event_decoder #(
        .TICK_COUNT   (4),
        .LONG_TICKS   (3),
        .REPEAT_TICKS (2)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .bus     (bif.slave)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample just after the following rising edge.
    task automatic step(input logic d, input logic ack, input logic clr);
        @(negedge clk_50M);
        bif.D_deb   = d;
        bif.ev_ack  = ack;
        bif.ovf_clr = clr;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bif.D_deb   = 1'b0;
        bif.ev_ack  = 1'b0;
        bif.ovf_clr = 1'b0;

        // Reset state
        @(posedge clk_50M);
        #1;
        chk("rst_valid", int'(bif.ev_valid), 0);
        chk("rst_code",  int'(bif.ev_code),  0);
        chk("rst_ovf",   int'(bif.ev_ovf),   0);
        chk("rst_held",  int'(bif.btn_held), 0);
        @(negedge clk_50M);
        rst = 1'b0;
        settle();

        // Scenario 1: short press, ack tied high
        for (int r = 0; r < 13; r++)
            tbl[r] = '{d: (r < 8), ack: 1'b1, clr: 1'b0, v: 1'b0, c: 2'd0, o: 1'b0, h: (r >= 2 && r < 10)};
        tbl[2].v  = 1'b1;
        tbl[10].v = 1'b1;
        for (int r = 10; r < 13; r++) tbl[r].c = 2'd1;
        for (int r = 0; r < 13; r++) begin
            step(tbl[r].d, tbl[r].ack, tbl[r].clr);
            chk($sformatf("s1_valid[%0d]", r), int'(bif.ev_valid), int'(tbl[r].v));
            chk($sformatf("s1_code[%0d]",  r), int'(bif.ev_code),  int'(tbl[r].c));
            chk($sformatf("s1_ovf[%0d]",   r), int'(bif.ev_ovf),   int'(tbl[r].o));
            chk($sformatf("s1_held[%0d]",  r), int'(bif.btn_held), int'(tbl[r].h));
        end
        settle();

        // Scenario 2: long hold with auto-repeat
        for (int r = 0; r < 46; r++) begin
            bit exp_v;
            int exp_c;
            step(r < 40, 1'b1, 1'b0);
            exp_v = (r == 2 || r == 14 || r == 22 || r == 30 || r == 38 || r == 42);
            exp_c = (r == 2) ? 0 : (r == 14) ? 2 : (r == 42) ? 1 : 3;
            chk($sformatf("s2_valid[%0d]", r), int'(bif.ev_valid), int'(exp_v));
            chk($sformatf("s2_held[%0d]",  r), int'(bif.btn_held), int'(r >= 2 && r < 42));
            if (exp_v) chk($sformatf("s2_code[%0d]", r), int'(bif.ev_code), exp_c);
        end
        settle();

        // Scenario 3: no ack, dropped events set overflow
        for (int r = 0; r < 23; r++) begin
            step(r < 20, 1'b0, 1'b0);
            if (r >= 2) begin
                chk($sformatf("s3_valid[%0d]", r), int'(bif.ev_valid), 1);
                chk($sformatf("s3_code[%0d]",  r), int'(bif.ev_code),  0);
                chk($sformatf("s3_ovf[%0d]",   r), int'(bif.ev_ovf),   int'(r >= 14));
            end
        end
        chk("s3_held_after_fall", int'(bif.btn_held), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("s3_ack_valid", int'(bif.ev_valid), 0);
        chk("s3_ovf_sticky", int'(bif.ev_ovf), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("s3_clr_valid", int'(bif.ev_valid), 0);
        chk("s3_clr_ovf", int'(bif.ev_ovf), 0);
        settle();

        // Scenario 4: fall on the same cycle as the LONG threshold tick
        for (int r = 0; r < 20; r++) begin
            step(r < 12, 1'b1, 1'b0);
            chk($sformatf("s4_valid[%0d]", r), int'(bif.ev_valid), int'(r == 2 || r == 14));
            if (r == 14) begin
                chk("s4_code_release", int'(bif.ev_code), 1);
                chk("s4_held_idle", int'(bif.btn_held), 0);
            end
            if (r == 13) chk("s4_held_before", int'(bif.btn_held), 1);
        end
        settle();

        // Scenario 6: ack lands on the REPEAT cycle, then scenario 5: reset mid-REPEAT
        for (int r = 0; r < 25; r++) begin
            step(1'b1, (r <= 14 || r == 22), 1'b0);
            if (r >= 14 && r <= 21) begin
                chk($sformatf("s6_valid[%0d]", r), int'(bif.ev_valid), 1);
                chk($sformatf("s6_code[%0d]",  r), int'(bif.ev_code),  2);
            end
            if (r >= 22) begin
                chk($sformatf("s6_valid[%0d]", r), int'(bif.ev_valid), 1);
                chk($sformatf("s6_code[%0d]",  r), int'(bif.ev_code),  3);
                chk($sformatf("s6_ovf[%0d]",   r), int'(bif.ev_ovf),   0);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        chk("s5_async_valid", int'(bif.ev_valid), 0);
        chk("s5_async_code",  int'(bif.ev_code),  0);
        chk("s5_async_ovf",   int'(bif.ev_ovf),   0);
        chk("s5_async_held",  int'(bif.btn_held), 0);
        @(posedge clk_50M);
        @(negedge clk_50M);
        rst = 1'b0;
        @(posedge clk_50M);
        #1;
        chk("s5_edge1_valid", int'(bif.ev_valid), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("s5_edge2_valid", int'(bif.ev_valid), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("s5_edge3_valid", int'(bif.ev_valid), 1);
        chk("s5_edge3_code",  int'(bif.ev_code),  0);
        chk("s5_edge3_held",  int'(bif.btn_held), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("s5_ack_valid", int'(bif.ev_valid), 0);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
